booth_wallace_mul_pipe: RTL and testbench

Parametrised radix-4 Booth / Wallace-tree integer multiplier with a fully stallable 3-stage pipeline. It is the next generation of the fixed 33-bit two-cycle multiplier. New features:
- XLEN generalised.
- Per-operand signed/unsigned mode (MUL/MULH/MULHSU/MULHU).
- Valid/ready backpressure on both sides.
- Flush.
- Tag passthrough.
It sits in the ALU execute path and returns the full 2*XLEN product.

---
 rtl/mul_pkg.sv | 56 +++++
 rtl/booth_pp_gen.sv | 42 ++++
 rtl/booth_wallace_mul_pipe.sv | 184 ++++++++++++++++++
 tb/tb_booth_wallace_mul_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the radix-4 Booth / Wallace-tree multiplier:
// internal width derivation, Booth digit encoding and operand mode flags.
package mul_pkg;

  // Internal operand width: XLEN+1 for the sign/zero extension, +1 to make it even
  function automatic int calc_w(input int xlen);
    return xlen + 2;
  endfunction

  // Number of radix-4 Booth partial products for an XLEN-bit multiplier
  function automatic int calc_npp(input int xlen);
    return (xlen + 2) / 2;
  endfunction

  // Number of 3:2 counter levels needed to bring 'rows' operands down to two
  function automatic int wallace_levels(input int rows);
    int n;
    int lv;
    n  = rows;
    lv = 0;
    while (n > 2) begin
      n  = 2 * (n / 3) + (n % 3);
      lv = lv + 1;
    end
    return lv;
  endfunction

  // Booth digit selections: multiple of the multiplicand to add
  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS1 = 3'd1,
    BOOTH_POS2 = 3'd2,
    BOOTH_NEG1 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_sel_e;

  // Per-operand interpretation (MUL/MULH = S/S, MULHSU = S/U, MULHU = U/U)
  typedef enum logic {
    OPD_UNSIGNED = 1'b0,
    OPD_SIGNED   = 1'b1
  } opd_mode_e;

  // Radix-4 Booth recoding of multiplier bits {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_sel_e booth_encode(input logic [2:0] bits);
    booth_sel_e sel;
    case (bits)
      3'b001, 3'b010: sel = BOOTH_POS1;
      3'b011:         sel = BOOTH_POS2;
      3'b100:         sel = BOOTH_NEG2;
      3'b101, 3'b110: sel = BOOTH_NEG1;
      default:        sel = BOOTH_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product, sign-extended to 2*W bits and left
// unshifted. Negative digits return the one's complement; the missing +1
// is reported on 'neg' so it can be added as a separate tree input.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int W = 34
) (
  input  logic [W-1:0]   mcand,
  input  logic [2:0]     bits,
  output logic [2*W-1:0] pp,
  output logic           neg
);

  booth_sel_e     sel;
  logic [2*W-1:0] ext;
  logic [2*W-1:0] mag;

  assign sel = booth_encode(bits);
  assign ext = {{W{mcand[W-1]}}, mcand};

  // Pick the multiple of the multiplicand and invert it for negative digits
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (sel)
      BOOTH_POS1: mag = ext;
      BOOTH_POS2: mag = ext << 1;
      BOOTH_NEG1: begin
        mag = ext;
        neg = 1'b1;
      end
      BOOTH_NEG2: begin
        mag = ext << 1;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    pp = neg ? ~mag : mag;
  end

endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// Three-stage, globally stalled radix-4 Booth / Wallace-tree multiplier
// returning the full 2*XLEN product with a passthrough tag.
//   S1: extended operands, S2: Wallace sum/carry, S3: final add.
module booth_wallace_mul_pipe
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_src1,
  input  logic [XLEN-1:0]     in_src2,
  input  logic                in_signed1,
  input  logic                in_signed2,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*XLEN-1:0]   out_result,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int W     = calc_w(XLEN);
  localparam int NPP   = calc_npp(XLEN);
  localparam int PW    = 2 * W;
  localparam int RW    = 2 * XLEN;
  localparam int NROWS = NPP + 1;
  localparam int NLVL  = wallace_levels(NROWS);

  // 3:2 counter: bitwise sum and the carry vector moved up one column
  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic              stall;
  logic              accept;
  opd_mode_e         mode1;
  opd_mode_e         mode2;
  logic              ext1;
  logic              ext2;

  logic              s1_valid;
  logic [W-1:0]      s1_a;
  logic [W-1:0]      s1_b;
  logic [TAG_W-1:0]  s1_tag;

  logic              s2_valid;
  logic [RW-1:0]     s2_sum;
  logic [RW-1:0]     s2_carry;
  logic [TAG_W-1:0]  s2_tag;

  logic [W:0]        b_ext;
  logic [PW-1:0]     pp_raw [NPP];
  logic [NPP-1:0]    pp_neg;
  logic [PW-1:0]     tree_q [NROWS];
  logic [PW-1:0]     tree_n [NROWS];
  int                tree_cnt;
  int                tree_k;

  // Global stall: a product waiting on the consumer freezes every stage.
  // Reset is folded in so the input side is closed while reset is held.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = reset & ~stall & ~flush;
  assign accept   = in_valid & in_ready;

  assign mode1 = opd_mode_e'(in_signed1);
  assign mode2 = opd_mode_e'(in_signed2);
  assign ext1  = (mode1 == OPD_SIGNED) & in_src1[XLEN-1];
  assign ext2  = (mode2 == OPD_SIGNED) & in_src2[XLEN-1];

  // Stage valid bits: cleared by reset or flush, frozen while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  // S1: capture operands extended to W bits (by sign or zero) plus the tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
    end else if (!stall) begin
      s1_a   <= {{2{ext1}}, in_src1};
      s1_b   <= {{2{ext2}}, in_src2};
      s1_tag <= in_tag;
    end
  end

  // Booth digit i looks at multiplier bits [2i+1:2i-1] with an implied 0 below bit 0
  assign b_ext = {s1_b, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_pp_gen #(.W(W)) u_pp (
      .mcand (s1_a),
      .bits  (b_ext[2*i+2:2*i]),
      .pp    (pp_raw[i]),
      .neg   (pp_neg[i])
    );
  end

  // Wallace reduction: shifted partials plus one row of negation +1 bits are
  // compressed level by level with 3:2 counters until two rows remain
  always_comb begin
    for (int r = 0; r < NROWS; r++) begin
      tree_q[r] = '0;
      tree_n[r] = '0;
    end
    for (int i = 0; i < NPP; i++) begin
      tree_q[i]        = pp_raw[i] << (2 * i);
      tree_q[NPP][2*i] = pp_neg[i];
    end
    tree_cnt = NROWS;
    tree_k   = 0;
    for (int lvl = 0; lvl < NLVL; lvl++) begin
      for (int r = 0; r < NROWS; r++) begin
        tree_n[r] = '0;
      end
      tree_k = 0;
      for (int g = 0; g < NROWS / 3; g++) begin
        if (3 * g + 2 < tree_cnt) begin
          tree_n[tree_k]     = csa_sum(tree_q[3*g], tree_q[3*g+1], tree_q[3*g+2]);
          tree_n[tree_k + 1] = csa_carry(tree_q[3*g], tree_q[3*g+1], tree_q[3*g+2]);
          tree_k             = tree_k + 2;
        end
      end
      for (int r = 0; r < NROWS; r++) begin
        if (r >= 3 * (tree_cnt / 3) && r < tree_cnt) begin
          tree_n[tree_k] = tree_q[r];
          tree_k         = tree_k + 1;
        end
      end
      for (int r = 0; r < NROWS; r++) begin
        tree_q[r] = tree_n[r];
      end
      tree_cnt = tree_k;
    end
  end

  // S2: register the two reduced rows; bits above 2*XLEN never reach the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
    end else if (!stall) begin
      s2_sum   <= tree_q[0][RW-1:0];
      s2_carry <= tree_q[1][RW-1:0];
      s2_tag   <= s1_tag;
    end
  end

  // S3: final carry-propagate add into the held output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (!stall) begin
      out_result <= s2_sum + s2_carry;
      out_tag    <= s2_tag;
    end
  end

endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Directed testbench for booth_wallace_mul_pipe at XLEN=32: signedness modes,
// latency, backpressure, flush and asynchronous reset.
module tb_booth_wallace_mul_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_src1;
  logic [XLEN-1:0]   in_src2;
  logic              in_signed1;
  logic              in_signed2;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [2*XLEN-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;

  int checks = 0;
  int errors = 0;

  booth_wallace_mul_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_signed1 (in_signed1),
    .in_signed2 (in_signed2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product of the extended operands, low 2*XLEN bits
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
    logic signed [127:0] ea;
    logic signed [127:0] eb;
    logic signed [127:0] p;
    ea = {{96{sa & a[31]}}, a};
    eb = {{96{sb & b[31]}}, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single operation on an empty pipeline: accept, exact 3-register latency, retire
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb, input logic [TAG_W-1:0] tag,
                       input logic [63:0] expected, input string name);
    flush      = 1'b0;
    out_ready  = 1'b1;
    in_src1    = a;
    in_src2    = b;
    in_signed1 = sa;
    in_signed2 = sb;
    in_tag     = tag;
    in_valid   = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s in_ready: got %b expected 1", name, in_ready);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s early_valid1: got %b expected 0", name, out_valid);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s early_valid2: got %b expected 0", name, out_valid);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_result !== expected || out_tag !== tag) begin
      errors++;
      $display("[TB] FAIL %s result: got v=%b r=%h t=%h expected v=1 r=%h t=%h",
               name, out_valid, out_result, out_tag, expected, tag);
    end
    tick;
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_src1    = '0;
    in_src2    = '0;
    in_signed1 = 1'b0;
    in_signed2 = 1'b0;
    in_tag     = '0;
    out_ready  = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b r=%h t=%h expected 0/0/0",
               out_valid, out_result, out_tag);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_modes;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 4'h1, 64'h0000000000000001, "ss_m1xm1");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h2, 64'hFFFFFFFE00000001, "uu_maxxmax");
    do_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 4'h3, 64'h4000000000000000, "ss_minxmin");
    do_op(32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0, 4'h4, 64'hFFFFFFFFFFFFFFFE, "su_m1x2");
    do_op(32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b1, 4'h5, 64'h00000001FFFFFFFE, "us_maxx2");
    do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 4'h6, 64'h3FFFFFFF00000001, "ss_maxpos");
    do_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 4'h7, 64'hC000000080000000, "ss_minxmax");
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h8, 64'h7FFFFFFF80000000, "uu_msbxmax");
    do_op(32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 4'h9, 64'hFFFFFFFFFFFFFFEB, "ss_m3x7");
    do_op(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 4'hA, 64'h0000000000000000, "ss_zero");
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_res [4];
    int          idx;
    int          budget;
    bit          pending;
    bit          taken;
    for (int i = 0; i < 4; i++) begin
      exp_res[i] = 64'((i + 1) * 3);
    end
    out_ready  = 1'b1;
    flush      = 1'b0;
    in_signed1 = 1'b0;
    in_signed2 = 1'b0;
    in_src2    = 32'd3;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_src1  = 32'(i + 1);
      in_tag   = 4'(i);
      tick;
    end
    in_src1   = 32'd4;
    in_tag    = 4'd3;
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 64'd3 || out_tag !== 4'd0) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle %0d: got v=%b r=%h t=%h expected v=1 r=3 t=0",
                 c, out_valid, out_result, out_tag);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_in_ready cycle %0d: got %b expected 0", c, in_ready);
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    idx     = 0;
    budget  = 0;
    pending = 1'b1;
    while (idx < 4 && budget < 20) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_tag !== 4'(idx) || out_result !== exp_res[idx]) begin
          errors++;
          $display("[TB] FAIL retire_order %0d: got r=%h t=%h expected r=%h t=%h",
                   idx, out_result, out_tag, exp_res[idx], 4'(idx));
        end
        idx++;
      end
      taken = pending && (in_ready === 1'b1);
      tick;
      if (taken) begin
        pending  = 1'b0;
        in_valid = 1'b0;
      end
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 4) begin
      errors++;
      $display("[TB] FAIL retire_count: got %0d expected 4", idx);
    end
    repeat (3) tick;
  endtask

  task automatic test_flush;
    // Flush with three ops in flight and the output stalled
    out_ready  = 1'b1;
    flush      = 1'b0;
    in_signed1 = 1'b0;
    in_signed2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_src1  = 32'(i + 10);
      in_src2  = 32'd5;
      in_tag   = 4'(i + 5);
      tick;
    end
    in_tag    = 4'd8;
    out_ready = 1'b0;
    flush     = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready);
    end
    tick;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_stall_valid cycle %0d: got %b expected 0", c, out_valid);
      end
      tick;
    end
    do_op(32'h00001234, 32'h00005678, 1'b0, 1'b0, 4'hB, 64'h0000000006260060, "post_flush1");

    // Flush with two ops in flight and no stall
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_src1  = 32'(i + 20);
      in_src2  = 32'd7;
      in_tag   = 4'(i + 12);
      tick;
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    tick;
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_valid cycle %0d: got %b expected 0", c, out_valid);
      end
      tick;
    end
    do_op(32'hFFFFFFF6, 32'h00000006, 1'b1, 1'b1, 4'hC, 64'hFFFFFFFFFFFFFFC4, "post_flush2");
  endtask

  task automatic test_reset_mid;
    out_ready  = 1'b1;
    flush      = 1'b0;
    in_signed1 = 1'b0;
    in_signed2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_src1  = 32'(i + 2);
      in_src2  = 32'd9;
      in_tag   = 4'(i + 1);
      tick;
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'd18) begin
      errors++;
      $display("[TB] FAIL pre_reset_result: got v=%b r=%h expected v=1 r=12", out_valid, out_result);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got v=%b r=%h t=%h expected 0/0/0",
               out_valid, out_result, out_tag);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    tick;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stale_after_reset cycle %0d: got %b expected 0", c, out_valid);
      end
      tick;
    end
    do_op(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 4'hD, 64'h00000000FFFE0001, "post_reset");
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    for (int i = 0; i < 100; i++) begin
      a  = $urandom;
      b  = $urandom;
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      do_op(a, b, sa, sb, 4'(i), ref_mul(a, b, sa, sb), "random");
    end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
